esn_tanh_seq: RTL
=================

// Module: esn_tanh_seq
// PURPOSE
//   Sequences a block of reservoir pre-activations through the shared af_tanh_kxb
//   activation pipeline and writes the results back to state memory.
//   Reads pre-activation words from a 1-cycle-latency RAM and feeds one word per
//   cycle into the tanh unit. The tanh unit has no enable and cannot stall.
//   Tracks every in-flight word with a valid/address delay line and writes each
//   result to the same address it was read from. Sits between the ESN update
//   controller (start/done) and the state RAM.
// PARAMETERS
//   N        32  IEEE-754 single word width
//   ADDR_W   8   state RAM address width; max vector length 2**ADDR_W-1
//   TANH_LAT 3   tanh_in -> tanh_out latency in clk cycles (af_tanh_kxb = 3)
// PORTS
//   clk      in   1       rising-edge clock
//   rst      in   1       asynchronous, active-high reset
//   start    in   1       1-cycle pulse: begin a pass; ignored unless IDLE
//   base     in   ADDR_W  first address of the vector, sampled with start
//   len      in   ADDR_W  number of words, sampled with start
//   abort    in   1       level; stop the pass (see BEHAVIOUR)
//   busy     out  1       high from the cycle after start until done/abort return to IDLE
//   done     out  1       1-cycle pulse after the last write-back
//   rd_en    out  1       RAM read strobe
//   rd_addr  out  ADDR_W  RAM read address
//   rd_data  in   N       RAM read data, valid 1 cycle after rd_en
//   tanh_in  out  N       to af_tanh_kxb.innum; combinational = rd_data
//   tanh_out in   N       from af_tanh_kxb.tanh_innum
//   wr_en    out  1       RAM write strobe
//   wr_addr  out  ADDR_W  RAM write address
//   wr_data  out  N       RAM write data; combinational = tanh_out
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, rd_en and wr_en = 0; rd_addr = 0.
//     The delay line is cleared.
//   FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE:  on start with len != 0: latch base/len, set cnt = 0, go to ISSUE.
//          On start with len == 0: go directly to DONE (no reads, no writes).
//   ISSUE: each cycle assert rd_en with rd_addr = base+cnt (mod 2**ADDR_W), then cnt++.
//          After len reads (cnt == len-1 issued), go to DRAIN.
//   DRAIN: issue nothing; stay until the delay line is empty, then go to DONE.
//   DONE:  done = 1 for exactly one cycle, busy = 0, go to IDLE.
//   Delay line: 1+TANH_LAT stages of {valid, addr}. It enters at rd_en and covers
//     the RAM latency plus TANH_LAT.
//     Stage-out drives wr_en/wr_addr in the same cycle that tanh_out holds the
//     result for that address.
//   Timing: read issued in cycle t -> rd_data/tanh_in at t+1 -> wr_en at t+1+TANH_LAT.
//     Throughput is 1 word/clk.
//     With start sampled at cycle 0 and TANH_LAT = 3:
//     - reads occur in cycles 1..len;
//     - writes occur in cycles 5..len+4;
//     - done occurs at cycle len+5.
//   Address wrap: base+len overflow wraps modulo 2**ADDR_W; this is legal.
//   start while busy: ignored; latched base/len are unchanged.
//   abort, sampled in ISSUE or DRAIN (takes priority over simultaneous transitions):
//     - the next cycle issues no reads;
//     - all delay-line valids are cleared, so no further wr_en;
//     - state = IDLE; busy drops; done is NOT pulsed.
//   abort in IDLE or DONE: no effect; a DONE pulse still completes.
//   rst mid-pass: immediate return to reset values. Any partially written vector
//     stays as-is in RAM.
//   Data is passed through unmodified; this block does no arithmetic on N-bit words.
// TESTING
//   1 base=0x10,len=4, RAM[0x10..0x13]={0x3F000000,0x41200000,0xC1200000,0}
//     -> reads cycles 1-4, writes cycles 5-8 to 0x10..0x13.
//     RAM[0x11]=0x3F800000, RAM[0x12]=0xBF800000; done at cycle 9.
//   2 len=0 start -> no rd_en/wr_en; busy high 1 cycle; done pulse at cycle 2.
//   3 base=0xFE,len=4 -> rd_addr sequence FE,FF,00,01; wr_addr same sequence 4 cycles later.
//   4 start again at cycle 3 of a len=8 pass with base=0x40
//     -> ignored; all 8 writes target the original base; a single done pulse.
//   5 abort at cycle 3 of len=8 -> exactly 2 reads; zero wr_en after the abort edge;
//     busy low at cycle 4; no done.
//   6 rst asserted mid-DRAIN -> all outputs 0 asynchronously.
//     Then start base=0,len=2 -> normal pass with done at cycle 7.

Source files
------------

// File: rtl/esn_tanh_seq_if.sv
// Sequencer bundle: controller handshake, state-RAM read/write ports and the tanh pipeline taps.
// No flow control; the sequencer (master) owns every strobe and address.
interface esn_tanh_seq_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [N-1:0]      rd_data;
    logic [N-1:0]      tanh_in;
    logic [N-1:0]      tanh_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [N-1:0]      wr_data;

    modport master (
        input  start, base, len, abort, rd_data, tanh_out,
        output busy, done, rd_en, rd_addr, tanh_in, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, base, len, abort, rd_data, tanh_out,
        input  busy, done, rd_en, rd_addr, tanh_in, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/esn_tanh_seq.sv
// Streams len words RAM -> tanh -> RAM at 1 word/clk; write lands 1+TANH_LAT cycles after its read,
// done 1+TANH_LAT+1 cycles after the last read. Never stalls: abort is the only way to stop a pass.
module esn_tanh_seq #(
    parameter int N        = 32,
    parameter int ADDR_W   = 8,
    parameter int TANH_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    esn_tanh_seq_if.master bus
);
    localparam int STAGES = 1 + TANH_LAT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              done_q;
    logic              issue;
    logic              kill;
    logic [STAGES-1:0] dl_vld;
    logic [ADDR_W-1:0] dl_addr [STAGES];

    // abort also masks the read of the cycle it is seen in, so nothing new enters the delay line
    assign kill  = bus.abort && (state == S_ISSUE || state == S_DRAIN);
    assign issue = (state == S_ISSUE) && !bus.abort;

    assign bus.rd_en   = issue;
    assign bus.rd_addr = base_q + cnt_q;
    assign bus.tanh_in = bus.rd_data;
    assign bus.wr_en   = dl_vld[STAGES-1];
    assign bus.wr_addr = dl_addr[STAGES-1];
    assign bus.wr_data = bus.tanh_out;
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            base_q <= bus.base;
                            len_q  <= bus.len;
                            cnt_q  <= '0;
                            state  <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (kill) begin
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // leave when only the output stage is left, so done lines up one cycle after the last write
                    if (kill)
                        state <= S_IDLE;
                    else if (dl_vld[STAGES-3:0] == '0)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < STAGES; i++)
                dl_addr[i] <= '0;
        end else begin
            if (kill)
                dl_vld <= '0;
            else
                dl_vld <= {dl_vld[STAGES-2:0], issue};
            dl_addr[0] <= bus.rd_addr;
            for (int i = 1; i < STAGES; i++)
                dl_addr[i] <= dl_addr[i-1];
        end
    end
endmodule
